// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the program counter and drives it straight onto the instruction
// memory address. Each unstalled cycle it captures the returned word into
// the IF/ID register. It supports:
//   - stalls that freeze the PC and IF/ID;
//   - flushes that insert a NOP bubble;
//   - branch/jump redirects.
// A redirect that arrives while stalled is parked in a pending-target
// register. It is applied once the stall clears, unless a newer redirect
// overrides it.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   stall        hazard hold: freeze PC and IF/ID
//   flush        squash IF/ID into a bubble on the next edge
//   pc_src       branch/jump taken, redirect the PC to pc_branch
//   pc_branch    redirect target (low two bits forced to zero)
//   imem_addr    instruction memory address (the PC register)
//   imem_rdata   instruction word for imem_addr, same cycle
//   if_id_pc     PC of the instruction held in IF/ID
//   if_id_instr  instruction held in IF/ID
//   if_id_valid  IF/ID holds a real instruction
//   fetch_err    sticky: a misaligned redirect target was seen
//   fetch_count  number of valid instructions delivered (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src,
  input  logic [31:0] pc_branch,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN,
    PEND
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] r_pendTarget;
  logic [31:0] r_ifIdPc;
  logic [31:0] r_ifIdInstr;
  logic        r_ifIdValid;
  logic        r_fetchErr;
  logic [31:0] r_fetchCount;

  logic [31:0] w_nextPc;
  logic [31:0] w_nextPend;
  logic [31:0] w_branchAligned;
  logic        w_branchMisaligned;
  logic        w_loadIfId;
  logic        w_squashIfId;

  assign w_branchAligned    = {pc_branch[31:2], 2'b00};
  assign w_branchMisaligned = |pc_branch[1:0];

  // Next-state logic.
  // Advancing (flush or plain run) picks the newest redirect first. If there
  // is none, it uses a parked target, and otherwise the sequential PC. A stall
  // only parks a redirect and leaves PC and IF/ID untouched.
  always_comb begin
    w_nextState  = r_state;
    w_nextPc     = r_pc;
    w_nextPend   = r_pendTarget;
    w_loadIfId   = 1'b0;
    w_squashIfId = 1'b0;
    if (flush || !stall) begin
      if (pc_src) begin
        w_nextPc = w_branchAligned;
      end else if (r_state == PEND) begin
        w_nextPc = r_pendTarget;
      end else begin
        w_nextPc = r_pc + 32'd4;
      end
      w_nextState  = RUN;
      w_squashIfId = flush;
      w_loadIfId   = !flush;
    end else if (pc_src) begin
      w_nextPend  = w_branchAligned;
      w_nextState = PEND;
    end
  end

  // PC, pending target, FSM state and IF/ID register.
  // Every pc_src is accepted on the edge it is seen, whether it is applied
  // directly or parked. So the alignment error is latched whenever pc_src is
  // high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_pendTarget <= 32'h0000_0000;
      r_ifIdPc     <= RESET_PC;
      r_ifIdInstr  <= NOP_INSTR;
      r_ifIdValid  <= 1'b0;
      r_fetchErr   <= 1'b0;
      r_fetchCount <= 32'h0000_0000;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_nextPc;
      r_pendTarget <= w_nextPend;
      if (pc_src && w_branchMisaligned) begin
        r_fetchErr <= 1'b1;
      end
      if (w_squashIfId) begin
        r_ifIdPc    <= r_pc;
        r_ifIdInstr <= NOP_INSTR;
        r_ifIdValid <= 1'b0;
      end else if (w_loadIfId) begin
        r_ifIdPc     <= r_pc;
        r_ifIdInstr  <= imem_rdata;
        r_ifIdValid  <= 1'b1;
        r_fetchCount <= r_fetchCount + 32'd1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_pc    = r_ifIdPc;
  assign if_id_instr = r_ifIdInstr;
  assign if_id_valid = r_ifIdValid;
  assign fetch_err   = r_fetchErr;
  assign fetch_count = r_fetchCount;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
//
// An asynchronous ROM model answers imem_addr:
//   - address 0 returns 32'h0050_0093;
//   - address 4 returns 32'h0000_A103;
//   - any other address returns addr ^ 32'hDEAD_0000.
// Inputs change 1ns after a rising edge, and outputs are sampled at that
// same point.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        pc_src;
  logic [31:0] pc_branch;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_err;
  logic [31:0] fetch_count;

  int nChecks = 0;
  int nFails  = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .pc_src     (pc_src),
    .pc_branch  (pc_branch),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_id_pc   (if_id_pc),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid),
    .fetch_err  (fetch_err),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    if (addr == 32'h4) return 32'h0000_A103;
    return addr ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = romWord(imem_addr);

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 1'b0; pc_branch = 32'h0;
    step();
    step();
    nChecks++; if (imem_addr !== 32'h0) begin nFails++; $display("[TB] FAIL reset_pc got %h want %h", imem_addr, 32'h0); end
    nChecks++; if (if_id_instr !== 32'h13) begin nFails++; $display("[TB] FAIL reset_instr got %h want %h", if_id_instr, 32'h13); end
    nChecks++; if (if_id_pc !== 32'h0) begin nFails++; $display("[TB] FAIL reset_ifid_pc got %h want %h", if_id_pc, 32'h0); end
    nChecks++; if (if_id_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid got %b want 0", if_id_valid); end
    nChecks++; if (fetch_err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_err got %b want 0", fetch_err); end
    nChecks++; if (fetch_count !== 32'h0) begin nFails++; $display("[TB] FAIL reset_count got %0d want 0", fetch_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    step();
    nChecks++; if (if_id_pc !== 32'h0) begin nFails++; $display("[TB] FAIL seq1_pc got %h want %h", if_id_pc, 32'h0); end
    nChecks++; if (if_id_instr !== 32'h0050_0093) begin nFails++; $display("[TB] FAIL seq1_instr got %h want %h", if_id_instr, 32'h0050_0093); end
    nChecks++; if (if_id_valid !== 1'b1) begin nFails++; $display("[TB] FAIL seq1_valid got %b want 1", if_id_valid); end
    nChecks++; if (imem_addr !== 32'h4) begin nFails++; $display("[TB] FAIL seq1_addr got %h want %h", imem_addr, 32'h4); end
    step();
    nChecks++; if (if_id_pc !== 32'h4) begin nFails++; $display("[TB] FAIL seq2_pc got %h want %h", if_id_pc, 32'h4); end
    nChecks++; if (if_id_instr !== 32'h0000_A103) begin nFails++; $display("[TB] FAIL seq2_instr got %h want %h", if_id_instr, 32'h0000_A103); end
    nChecks++; if (fetch_count !== 32'd2) begin nFails++; $display("[TB] FAIL seq2_count got %0d want 2", fetch_count); end
    nChecks++; if (imem_addr !== 32'h8) begin nFails++; $display("[TB] FAIL seq2_addr got %h want %h", imem_addr, 32'h8); end
  endtask

  task automatic test_branch();
    pc_src = 1'b1; pc_branch = 32'h40;
    step();
    pc_src = 1'b0;
    nChecks++; if (imem_addr !== 32'h40) begin nFails++; $display("[TB] FAIL br_addr got %h want %h", imem_addr, 32'h40); end
    nChecks++; if (if_id_pc !== 32'h8) begin nFails++; $display("[TB] FAIL br_ifid_pc got %h want %h", if_id_pc, 32'h8); end
    nChecks++; if (if_id_instr !== 32'hDEAD_0008) begin nFails++; $display("[TB] FAIL br_instr got %h want %h", if_id_instr, 32'hDEAD_0008); end
    nChecks++; if (fetch_count !== 32'd3) begin nFails++; $display("[TB] FAIL br_count got %0d want 3", fetch_count); end
  endtask

  task automatic test_stall_redirect();
    pc_src = 1'b1; pc_branch = 32'h10;
    step();
    nChecks++; if (imem_addr !== 32'h10) begin nFails++; $display("[TB] FAIL st_setup_addr got %h want %h", imem_addr, 32'h10); end
    stall = 1'b1; pc_src = 1'b1; pc_branch = 32'h80;
    step();
    pc_src = 1'b0; pc_branch = 32'h0;
    nChecks++; if (imem_addr !== 32'h10) begin nFails++; $display("[TB] FAIL st1_addr got %h want %h", imem_addr, 32'h10); end
    nChecks++; if (if_id_pc !== 32'h40) begin nFails++; $display("[TB] FAIL st1_ifid_pc got %h want %h", if_id_pc, 32'h40); end
    for (int i = 0; i < 2; i++) begin
      step();
      nChecks++; if (imem_addr !== 32'h10) begin nFails++; $display("[TB] FAIL st_hold_addr got %h want %h", imem_addr, 32'h10); end
      nChecks++; if (fetch_count !== 32'd4) begin nFails++; $display("[TB] FAIL st_hold_count got %0d want 4", fetch_count); end
    end
    stall = 1'b0;
    step();
    nChecks++; if (imem_addr !== 32'h80) begin nFails++; $display("[TB] FAIL st_release_addr got %h want %h", imem_addr, 32'h80); end
    nChecks++; if (if_id_pc !== 32'h10) begin nFails++; $display("[TB] FAIL st_release_ifid_pc got %h want %h", if_id_pc, 32'h10); end
    nChecks++; if (if_id_instr !== 32'hDEAD_0010) begin nFails++; $display("[TB] FAIL st_release_instr got %h want %h", if_id_instr, 32'hDEAD_0010); end
    nChecks++; if (fetch_count !== 32'd5) begin nFails++; $display("[TB] FAIL st_release_count got %0d want 5", fetch_count); end
  endtask

  task automatic test_flush_over_stall();
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    nChecks++; if (if_id_instr !== 32'h0000_0013) begin nFails++; $display("[TB] FAIL fl_instr got %h want %h", if_id_instr, 32'h13); end
    nChecks++; if (if_id_valid !== 1'b0) begin nFails++; $display("[TB] FAIL fl_valid got %b want 0", if_id_valid); end
    nChecks++; if (fetch_count !== 32'd5) begin nFails++; $display("[TB] FAIL fl_count got %0d want 5", fetch_count); end
    nChecks++; if (imem_addr !== 32'h84) begin nFails++; $display("[TB] FAIL fl_addr got %h want %h", imem_addr, 32'h84); end
    nChecks++; if (if_id_pc !== 32'h80) begin nFails++; $display("[TB] FAIL fl_ifid_pc got %h want %h", if_id_pc, 32'h80); end
  endtask

  task automatic test_misaligned_wrap();
    nChecks++; if (fetch_err !== 1'b0) begin nFails++; $display("[TB] FAIL mis_pre_err got %b want 0", fetch_err); end
    pc_src = 1'b1; pc_branch = 32'h0000_0102;
    step();
    pc_src = 1'b0;
    nChecks++; if (imem_addr !== 32'h100) begin nFails++; $display("[TB] FAIL mis_addr got %h want %h", imem_addr, 32'h100); end
    nChecks++; if (fetch_err !== 1'b1) begin nFails++; $display("[TB] FAIL mis_err got %b want 1", fetch_err); end
    step();
    nChecks++; if (imem_addr !== 32'h104) begin nFails++; $display("[TB] FAIL mis_next_addr got %h want %h", imem_addr, 32'h104); end
    nChecks++; if (fetch_err !== 1'b1) begin nFails++; $display("[TB] FAIL mis_sticky_err got %b want 1", fetch_err); end
    pc_src = 1'b1; pc_branch = 32'hFFFF_FFFC;
    step();
    pc_src = 1'b0;
    nChecks++; if (imem_addr !== 32'hFFFF_FFFC) begin nFails++; $display("[TB] FAIL wrap_pre_addr got %h want %h", imem_addr, 32'hFFFF_FFFC); end
    step();
    nChecks++; if (imem_addr !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_addr got %h want %h", imem_addr, 32'h0); end
    nChecks++; if (if_id_pc !== 32'hFFFF_FFFC) begin nFails++; $display("[TB] FAIL wrap_ifid_pc got %h want %h", if_id_pc, 32'hFFFF_FFFC); end
    nChecks++; if (fetch_count !== 32'd9) begin nFails++; $display("[TB] FAIL wrap_count got %0d want 9", fetch_count); end
    nChecks++; if (fetch_err !== 1'b1) begin nFails++; $display("[TB] FAIL wrap_err got %b want 1", fetch_err); end
  endtask

  task automatic test_async_reset_pend();
    step();
    nChecks++; if (imem_addr !== 32'h4) begin nFails++; $display("[TB] FAIL ar_setup_addr got %h want %h", imem_addr, 32'h4); end
    stall = 1'b1; pc_src = 1'b1; pc_branch = 32'h200;
    step();
    pc_src = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++; if (imem_addr !== 32'h0) begin nFails++; $display("[TB] FAIL ar_addr got %h want %h", imem_addr, 32'h0); end
    nChecks++; if (if_id_instr !== 32'h13) begin nFails++; $display("[TB] FAIL ar_instr got %h want %h", if_id_instr, 32'h13); end
    nChecks++; if (if_id_pc !== 32'h0) begin nFails++; $display("[TB] FAIL ar_ifid_pc got %h want %h", if_id_pc, 32'h0); end
    nChecks++; if (if_id_valid !== 1'b0) begin nFails++; $display("[TB] FAIL ar_valid got %b want 0", if_id_valid); end
    nChecks++; if (fetch_err !== 1'b0) begin nFails++; $display("[TB] FAIL ar_err got %b want 0", fetch_err); end
    nChecks++; if (fetch_count !== 32'h0) begin nFails++; $display("[TB] FAIL ar_count got %0d want 0", fetch_count); end
    step();
    rst_n = 1'b1; stall = 1'b0;
    step();
    nChecks++; if (if_id_pc !== 32'h0) begin nFails++; $display("[TB] FAIL ar_rel_ifid_pc got %h want %h", if_id_pc, 32'h0); end
    nChecks++; if (if_id_instr !== 32'h0050_0093) begin nFails++; $display("[TB] FAIL ar_rel_instr got %h want %h", if_id_instr, 32'h0050_0093); end
    nChecks++; if (imem_addr !== 32'h4) begin nFails++; $display("[TB] FAIL ar_rel_addr got %h want %h", imem_addr, 32'h4); end
  endtask

  task automatic test_flush_pending();
    stall = 1'b1; pc_src = 1'b1; pc_branch = 32'h301;
    step();
    pc_src = 1'b0;
    nChecks++; if (imem_addr !== 32'h4) begin nFails++; $display("[TB] FAIL fp_hold_addr got %h want %h", imem_addr, 32'h4); end
    nChecks++; if (fetch_err !== 1'b1) begin nFails++; $display("[TB] FAIL fp_err got %b want 1", fetch_err); end
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    nChecks++; if (imem_addr !== 32'h300) begin nFails++; $display("[TB] FAIL fp_addr got %h want %h", imem_addr, 32'h300); end
    nChecks++; if (if_id_valid !== 1'b0) begin nFails++; $display("[TB] FAIL fp_valid got %b want 0", if_id_valid); end
    nChecks++; if (if_id_pc !== 32'h4) begin nFails++; $display("[TB] FAIL fp_ifid_pc got %h want %h", if_id_pc, 32'h4); end
    nChecks++; if (fetch_count !== 32'd1) begin nFails++; $display("[TB] FAIL fp_count got %0d want 1", fetch_count); end
    step();
    nChecks++; if (imem_addr !== 32'h304) begin nFails++; $display("[TB] FAIL fp_next_addr got %h want %h", imem_addr, 32'h304); end
    nChecks++; if (if_id_instr !== 32'hDEAD_0300) begin nFails++; $display("[TB] FAIL fp_next_instr got %h want %h", if_id_instr, 32'hDEAD_0300); end
  endtask

  // Watchdog so the run always ends even if something stops advancing.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout reached, got no finish want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_redirect();
    test_flush_over_stall();
    test_misaligned_wrap();
    test_async_reset_pend();
    test_flush_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
